bcd_seg_core: RTL and testbench
===============================

BCD_SEG_CORE -- requirements
Module: bcd_seg_core

Interface
REQ-001 Parameter HALF_PERIOD, default 50000, clock cycles per half-period of ms_clock (1 ms period at 100 MHz); legal range >= 2.
REQ-002 One clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-003 clock  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 bin_in  input  27  unsigned binary value to convert.
REQ-006 digit_in  input  4  nibble to render on the seven-segment decoder.
REQ-007 dp_in  input  1  decimal point request; 1 = lit.
REQ-008 ms_clock  output  1  divided square wave, 50% duty, period 2*HALF_PERIOD cycles.
REQ-009 bcd_out  output  32  eight packed BCD digits; [3:0] = ones, [31:28] = ten-millions.
REQ-010 overflow  output  1  registered flag; 1 when bin_in > 99,999,999.
REQ-011 cathode  output  8  active-low segments {DP,G,F,E,D,C,B,A}; bit 7 = DP, bit 0 = A.

Function
REQ-012 Divider SHALL hold a counter ceil(log2(HALF_PERIOD)) bits wide that counts 0..HALF_PERIOD-1 and wraps to 0.
REQ-013 On the edge where the counter equals HALF_PERIOD-1, the counter SHALL go to 0 and ms_clock SHALL toggle; no other edge changes ms_clock.
REQ-014 First ms_clock rise SHALL occur on the HALF_PERIOD-th rising clock edge after reset deasserts; after that, ms_clock toggles every HALF_PERIOD edges.
REQ-015 Converter SHALL compute the decimal digits of bin_in combinationally by shift-add-3 or equivalent, then register them into bcd_out; latency is exactly 1 clock edge.
REQ-016 Each bcd_out nibble SHALL be in 0..9.
REQ-017 For bin_in <= 99,999,999, bcd_out SHALL equal the exact decimal value, zero-padded, and overflow SHALL be 0.
REQ-018 For bin_in > 99,999,999 (max 134,217,727), bcd_out SHALL saturate to 32'h99999999 and overflow SHALL be 1, on the same edge.
REQ-019 bcd_out and overflow SHALL update on every clock edge; there is no enable or handshake.
REQ-020 Decoder SHALL be purely combinational from digit_in and dp_in, with no clock latency.
REQ-021 cathode[6:0], given as cathode hex with DP dark: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
REQ-022 cathode[7] SHALL be ~dp_in, independent of digit_in.
REQ-023 cathode SHALL be unaffected by reset.
REQ-024 Divider and converter SHALL be independent: bin_in changes SHALL NOT disturb the divider count.

Reset
REQ-025 While reset=1, counter SHALL be 0, ms_clock SHALL be 0, bcd_out SHALL be 32'h0 and overflow SHALL be 0, immediately and without a clock edge.
REQ-026 Reset asserted mid-period SHALL restart the divider; REQ-014 timing applies from the deassertion edge.
REQ-027 On the first edge after reset deasserts, bcd_out SHALL reflect bin_in.

Verification
REQ-028 HALF_PERIOD=4, release reset -> ms_clock rises on edge 4, falls on edge 8, rises on edge 12; high 4, low 4 thereafter.
REQ-029 bin_in=0, 9, 10, 12345678, 99999999 -> one edge later bcd_out = 0, 00000009, 00000010, 12345678, 99999999, overflow=0 each.
REQ-030 bin_in=100000000, then 134217727 -> bcd_out=99999999 with overflow=1; then bin_in=5 -> bcd_out=00000005, overflow=0 on the next edge.
REQ-031 Sweep digit_in 0..F with dp_in=0 -> cathode matches the REQ-021 table; repeat with dp_in=1 -> same codes with bit 7 cleared (e.g. 0 -> 40).
REQ-032 Assert reset asynchronously at divider count 2, between edges -> ms_clock, bcd_out and overflow go to 0 at once; after release the REQ-028 timing repeats.

Source files
------------

// File: rtl/bcd_seg_core.sv
// bcd_seg_core: ms square-wave divider, 27-bit binary to 8-digit BCD converter, 7-seg decoder
//   clock    : system clock, all state on rising edge
//   reset    : asynchronous active-high reset (divider and converter only)
//   bin_in   : 27-bit unsigned value to convert
//   digit_in : nibble to render on the seven-segment decoder
//   dp_in    : decimal point request, 1 = lit
//   ms_clock : divided square wave, period 2*HALF_PERIOD cycles
//   bcd_out  : registered packed BCD, [3:0] = ones, saturates to 99999999
//   overflow : registered, 1 when bin_in > 99,999,999
//   cathode  : active-low segments {DP,G,F,E,D,C,B,A}, combinational
module bcd_seg_core #(
    parameter int HALF_PERIOD = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [26:0] bin_in,
    input  logic [3:0]  digit_in,
    input  logic        dp_in,
    output logic        ms_clock,
    output logic [31:0] bcd_out,
    output logic        overflow,
    output logic [7:0]  cathode
);
    localparam int CW = $clog2(HALF_PERIOD);

    logic [CW-1:0] count;
    logic [31:0]   shift;
    logic [31:0]   bcd_next;
    logic          overflow_next;
    logic [6:0]    seg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            ms_clock <= 1'b0;
        end else if (count == CW'(HALF_PERIOD - 1)) begin
            count    <= '0;
            ms_clock <= ~ms_clock;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Shift-add-3 into eight digits; carries out of the top digit only occur
    // for values above 99,999,999, which are replaced by the saturated code.
    always_comb begin
        shift = '0;
        for (int i = 26; i >= 0; i--) begin
            for (int j = 0; j < 8; j++)
                if (shift[4*j +: 4] >= 4'd5) shift[4*j +: 4] = shift[4*j +: 4] + 4'd3;
            shift = {shift[30:0], bin_in[i]};
        end
        overflow_next = bin_in > 27'd99999999;
        bcd_next      = overflow_next ? 32'h99999999 : shift;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            bcd_out  <= bcd_next;
            overflow <= overflow_next;
        end
    end

    always_comb begin
        seg = 7'h7F;
        case (digit_in)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        cathode = {~dp_in, seg};
    end
endmodule

// File: tb/tb_bcd_seg_core.sv
// tb_bcd_seg_core: self-checking bench for bcd_seg_core with HALF_PERIOD=4
module tb_bcd_seg_core;
    localparam int HP = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [26:0] bin_in;
    logic [3:0]  digit_in;
    logic        dp_in;
    logic        ms_clock;
    logic [31:0] bcd_out;
    logic        overflow;
    logic [7:0]  cathode;

    int checks = 0;
    int failures = 0;
    int n = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    bcd_seg_core #(.HALF_PERIOD(HP)) dut (
        .clock(clock), .reset(reset), .bin_in(bin_in), .digit_in(digit_in), .dp_in(dp_in),
        .ms_clock(ms_clock), .bcd_out(bcd_out), .overflow(overflow), .cathode(cathode)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r = '0;
        if (v > 99999999) return 32'h99999999;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply v, take one edge, then check divider phase and registered conversion.
    task automatic edge_with(input logic [26:0] v);
        bin_in = v;
        @(posedge clock);
        #1;
        n++;
        chk("ms_clock", {31'b0, ms_clock}, {31'b0, 1'((n / HP) % 2)});
        chk("bcd_out", bcd_out, to_bcd(v));
        chk("overflow", {31'b0, overflow}, {31'b0, v > 27'd99999999});
    endtask

    task automatic seg_sweep();
        for (int d = 0; d < 16; d++) begin
            for (int p = 0; p < 2; p++) begin
                digit_in = 4'(d);
                dp_in    = 1'(p);
                #1;
                chk("cathode", {24'b0, cathode}, {24'b0, p == 1 ? seg_tab[d] & 8'h7F : seg_tab[d]});
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        bin_in   = 27'd12345;
        digit_in = 4'h0;
        dp_in    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ms", {31'b0, ms_clock}, 32'h0);
        chk("rst_bcd", bcd_out, 32'h0);
        chk("rst_ovf", {31'b0, overflow}, 32'h0);
        seg_sweep();
        reset = 1'b0;
        n = 0;
        edge_with(27'd0);
        edge_with(27'd9);
        edge_with(27'd10);
        edge_with(27'd12345678);
        edge_with(27'd99999999);
        edge_with(27'd100000000);
        edge_with(27'd134217727);
        edge_with(27'd5);
        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0: edge_with(27'($urandom_range(0, 134217727)));
                1: edge_with(27'($urandom_range(99999990, 100000010)));
                2: edge_with(27'($urandom_range(0, 99999)));
                default: edge_with(27'($urandom_range(0, 99999999)));
            endcase
        end
        while (n % (2 * HP) != 6) edge_with(27'($urandom_range(0, 99999999)));
        bin_in = 27'd87654321;
        #2;
        reset = 1'b1;
        #1;
        chk("async_ms", {31'b0, ms_clock}, 32'h0);
        chk("async_bcd", bcd_out, 32'h0);
        chk("async_ovf", {31'b0, overflow}, 32'h0);
        @(posedge clock);
        #1;
        chk("held_ms", {31'b0, ms_clock}, 32'h0);
        chk("held_bcd", bcd_out, 32'h0);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 3 * HP; i++) edge_with(27'($urandom_range(0, 134217727)));
        seg_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
